// File: rtl/channel_readout.sv
// -----------------------------------------------------------------------------
// channel_readout
//
// Frame-based readout engine for the spectrogram channel counters. A free-running
// frame timer raises a tick every FRAME_CYCLES clocks. On a tick taken from idle,
// the engine freezes the counters, captures every channel's count and overflow
// flag into a shadow register, clears the counters, and then shifts the captured
// frame out one bit at a time over a valid/ready handshake.
//
// Frame format: channel 0 first, each channel a {ovf, data[WIDTH-1:0]} word sent
// MSB first, N_CH*(WIDTH+1) bits in total. sout_last marks the final bit.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous, active-high reset
//   ch_data        counter values, channel k at [k*WIDTH +: WIDTH]
//   ch_ovf         counter overflow flags, bit k = channel k
//   cnt_freeze     high stops the counters (drives their enable)
//   cnt_reset      high clears the counters; also held high during reset
//   sout           serial data bit
//   sout_valid     sout holds a valid bit
//   sout_ready     sink accepts the bit when high together with sout_valid
//   sout_last      current bit is the last bit of the frame
//   frame_overrun  sticky: a tick arrived while a frame was still in progress
//
// Build option:
//   READOUT_SATURATE_EN  when defined, a channel captured with ovf=1 sends all-ones
//                        data bits; otherwise the raw wrapped count is sent.
// -----------------------------------------------------------------------------
module channel_readout #(
  parameter int N_CH         = 8,
  parameter int WIDTH        = 12,
  parameter int FRAME_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CH*WIDTH-1:0] ch_data,
  input  logic [N_CH-1:0]       ch_ovf,
  output logic                  cnt_freeze,
  output logic                  cnt_reset,
  output logic                  sout,
  output logic                  sout_valid,
  input  logic                  sout_ready,
  output logic                  sout_last,
  output logic                  frame_overrun
);

  localparam int WORD_W     = WIDTH + 1;
  localparam int FRAME_BITS = N_CH * WORD_W;
  localparam int TW         = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam int BW         = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FREEZE,
    ST_LATCH,
    ST_CLEAR,
    ST_SHIFT
  } state_t;

  state_t                  state_q, state_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic                    frz_cnt_q, frz_cnt_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
  logic                    sout_q, sout_d;
  logic                    sout_valid_q, sout_valid_d;
  logic                    sout_last_q, sout_last_d;
  logic                    cnt_freeze_q, cnt_freeze_d;
  logic                    cnt_reset_q, cnt_reset_d;
  logic                    overrun_q, overrun_d;
  logic                    tick;
  logic                    accept;

  // Builds one channel word; with saturation enabled an overflowed channel
  // reports full scale instead of its wrapped count.
  function automatic logic [WORD_W-1:0] pack_word(input logic ovf,
                                                  input logic [WIDTH-1:0] data);
`ifdef READOUT_SATURATE_EN
    pack_word = {ovf, (ovf ? {WIDTH{1'b1}} : data)};
`else
    pack_word = {ovf, data};
`endif
  endfunction

  always_comb begin
    tick    = (timer_q == TW'(FRAME_CYCLES - 1));
    timer_d = tick ? '0 : timer_q + 1'b1;
    accept  = sout_valid_q && sout_ready;

    state_d     = state_q;
    frz_cnt_d   = frz_cnt_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    sout_d      = sout_q;
    sout_last_d = sout_last_q;
    // A tick seen anywhere but idle is dropped; the counters keep accumulating.
    overrun_d   = overrun_q | (tick && (state_q != ST_IDLE));

    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          state_d   = ST_FREEZE;
          frz_cnt_d = 1'b0;
        end
      end
      // Two frozen cycles let the impulse-domain counters settle.
      ST_FREEZE: begin
        if (frz_cnt_q) begin
          state_d = ST_LATCH;
        end else begin
          frz_cnt_d = 1'b1;
        end
      end
      ST_LATCH: begin
        // Channel 0 occupies the top word so it leaves first.
        for (int k = 0; k < N_CH; k++) begin
          shift_d[FRAME_BITS-1-k*WORD_W -: WORD_W] =
            pack_word(ch_ovf[k], ch_data[k*WIDTH +: WIDTH]);
        end
        state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        // Preload the first bit so it is presented together with sout_valid.
        sout_d      = shift_q[FRAME_BITS-1];
        shift_d     = shift_q << 1;
        bit_cnt_d   = '0;
        sout_last_d = 1'b0;
        state_d     = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (accept) begin
          if (sout_last_q) begin
            state_d     = ST_IDLE;
            sout_d      = 1'b0;
            sout_last_d = 1'b0;
          end else begin
            sout_d      = shift_q[FRAME_BITS-1];
            shift_d     = shift_q << 1;
            bit_cnt_d   = bit_cnt_q + 1'b1;
            sout_last_d = (bit_cnt_d == BW'(FRAME_BITS - 1));
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered copies of what the next state requires.
    cnt_freeze_d = (state_d == ST_FREEZE) || (state_d == ST_LATCH) ||
                   (state_d == ST_CLEAR);
    cnt_reset_d  = (state_d == ST_CLEAR);
    sout_valid_d = (state_d == ST_SHIFT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      frz_cnt_q    <= 1'b0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      sout_last_q  <= 1'b0;
      cnt_freeze_q <= 1'b0;
      cnt_reset_q  <= 1'b1;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      frz_cnt_q    <= frz_cnt_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      sout_last_q  <= sout_last_d;
      cnt_freeze_q <= cnt_freeze_d;
      cnt_reset_q  <= cnt_reset_d;
      overrun_q    <= overrun_d;
    end
  end

  assign cnt_freeze    = cnt_freeze_q;
  assign cnt_reset     = cnt_reset_q;
  assign sout          = sout_q;
  assign sout_valid    = sout_valid_q;
  assign sout_last     = sout_last_q;
  assign frame_overrun = overrun_q;

endmodule
